alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, handshaked successor to the 8-bit combinational datapath ALU. It widens the operand width and adds XOR, signed set-less-than, logical shift-left and an iterative shift-add multiply. It also produces a full flag set (Z/N/C/V). The result and flags are registered and held under valid/ready backpressure, so the block can sit between the register-read stage and writeback of a multi-cycle CPU.

Parameters:
WIDTH, 8, operand/result width; must be a power of 2, >= 4
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands and opcode valid
in_ready  output  1  block can accept an operation
SrcA  input  WIDTH  operand A
SrcB  input  WIDTH  operand B
ALUControl  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SLT, 110 SLL, 111 MUL
out_valid  output  1  ALUResult/flags valid
out_ready  input  1  consumer accepts the result
ALUResult  output  WIDTH  registered result
Zero  output  1  ALUResult == 0
Negative  output  1  ALUResult[WIDTH-1]
Carry  output  1  ADD: carry-out; SUB: 1 when SrcA >= SrcB unsigned (no borrow); all other ops: 0
Overflow  output  1  signed overflow for ADD/SUB; all other ops: 0
busy  output  1  high in BUSY state (multiply in progress)

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset -> IDLE.
- Reset values: ALUResult=0, all flags=0, out_valid=0, busy=0, multiply registers and iteration counter=0. in_ready=1 in the cycle after reset.
- in_ready = (state==IDLE). out_valid = (state==DONE). Accept happens on in_valid && in_ready.
- IDLE, accept of a non-MUL op:
  - Compute combinationally from SrcA/SrcB.
  - Register the result and all four flags.
  - Go to DONE. out_valid rises on the cycle after accept (latency 1).
- IDLE, accept of MUL:
  - Load mcand=SrcA, mplier=SrcB, acc=0, cnt=0. Go to BUSY.
- BUSY, one iteration per cycle:
  - If mplier[0], acc = acc + mcand, computed mod 2^WIDTH.
  - mcand <<= 1; mplier >>= 1; cnt++.
  - After the WIDTH-th iteration, write acc to ALUResult with flags Z/N from acc and C=V=0, then go to DONE.
  - MUL latency: out_valid rises WIDTH+1 cycles after the accept edge. No early termination.
- DONE: outputs held stable. If out_ready, go to IDLE; out_valid drops the next cycle. Without out_ready, DONE holds indefinitely and in_valid is ignored.
- Throughput: one op per 2 cycles (non-MUL) or per WIDTH+2 cycles (MUL) with out_ready tied high.
- Arithmetic:
  - ADD/SUB use a WIDTH+1-bit sum; SUB is A + ~B + 1, and Carry is the bit WIDTH of that sum.
  - Overflow is set when the operands' MSBs match (ADD) or differ (SUB) and the result MSB differs from A's MSB.
  - SLT: result = {WIDTH-1 zeros, signed(A) < signed(B)}.
  - SLL: A << SrcB[SHW-1:0]; the upper bits of SrcB are ignored.
  - MUL: low WIDTH bits of the unsigned product. Signed operands give the correct low bits, since two's-complement low bits are sign-independent.
- Zero and Negative are always derived from the registered result, for every op.
- Operands are captured at accept. SrcA/SrcB/ALUControl changes after accept have no effect.
- Reset in any state, including mid-MUL or in DONE with out_ready low: return to IDLE next edge, discard the result, clear all outputs. No partial result ever appears.
- ALUControl is 3 bits with all 8 codes defined, so there is no illegal opcode.

Test Plan:
1. WIDTH=8, ADD A=0xFF B=0x01, out_ready=1 -> out_valid one cycle after accept; ALUResult=0x00, Z=1, C=1, V=0, N=0; in_ready back high one cycle after the result is taken.
2. SUB A=0x80 B=0x01 -> 0x7F, V=1, C=1, N=0. Then SUB A=0x01 B=0x02 -> 0xFF, C=0, N=1, V=0. Then SLT A=0xFE B=0x01 -> 0x01.
3. MUL A=13 B=11 -> busy high for 8 cycles; out_valid exactly 9 cycles after accept; ALUResult=0x8F. Then MUL 0x10*0x10 -> 0x00, Z=1, C=0, V=0.
4. Backpressure: ADD A=3 B=4 with out_ready=0 for 5 cycles -> ALUResult=0x07 held stable with out_valid=1. in_ready=0 and in_valid pulses are ignored. On out_ready=1 the result is taken once.
5. Reset asserted 4 cycles into MUL -> next cycle: IDLE, out_valid=0, ALUResult=0, busy=0, in_ready=1. A following OR A=0xA0 B=0x0A -> 0xAA.
6. WIDTH=16: SLL A=0x0001 B=0x001F (uses B[3:0]=15) -> 0x8000, N=1. MUL 0x0100*0x0100 -> 0x0000, Z=1, out_valid 17 cycles after accept. XOR 0xFFFF^0xFFFF -> 0, Z=1.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith ops plus an iterative
// shift-add multiply, with the result and Z/N/C/V flags held until taken.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH-1);

  localparam logic [2:0] OP_AND = 3'b000, OP_OR  = 3'b001, OP_ADD = 3'b010,
                         OP_SUB = 3'b011, OP_XOR = 3'b100, OP_SLT = 3'b101,
                         OP_SLL = 3'b110, OP_MUL = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
  logic [SHW:0]     cnt;

  logic             is_sub, c, v;
  logic [WIDTH-1:0] bop, res;
  logic [WIDTH:0]   sum;

  // SUB shares the adder as A + ~B + 1, so its carry-out means "no borrow".
  always_comb begin
    is_sub = (ALUControl == OP_SUB);
    bop    = is_sub ? ~SrcB : SrcB;
    sum    = {1'b0, SrcA} + {1'b0, bop} + {{WIDTH{1'b0}}, is_sub};
    res    = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (ALUControl)
      OP_AND: res = SrcA & SrcB;
      OP_OR:  res = SrcA | SrcB;
      OP_ADD, OP_SUB: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (SrcA[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_XOR: res = SrcA ^ SrcB;
      OP_SLT: res = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      OP_SLL: res = SrcA << SrcB[SHW-1:0];
      default: res = '0;
    endcase
  end

  assign acc_nxt = mplier[0] ? acc + mcand : acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b0;
      Negative  <= 1'b0;
      Carry     <= 1'b0;
      Overflow  <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          if (ALUControl == OP_MUL) begin
            mcand  <= SrcA;
            mplier <= SrcB;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= BUSY;
          end else begin
            ALUResult <= res;
            Zero      <= (res == '0);
            Negative  <= res[WIDTH-1];
            Carry     <= c;
            Overflow  <= v;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Fixed WIDTH iterations regardless of operand values.
          if (cnt == CNT_LAST) begin
            ALUResult <= acc_nxt;
            Zero      <= (acc_nxt == '0);
            Negative  <= acc_nxt[WIDTH-1];
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=8 and WIDTH=16.
module tb_alu_seq;
  localparam logic [2:0] AND_ = 3'b000, OR_ = 3'b001, ADD = 3'b010, SUB = 3'b011,
                         XOR_ = 3'b100, SLT = 3'b101, SLL = 3'b110, MUL = 3'b111;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a, b, r;
    logic [3:0]  f;      // {Z,N,C,V}
    logic [7:0]  lat;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic        iv8 = 0, ir8, ov8, ordy8 = 1, z8, n8, c8, v8, busy8;
  logic [7:0]  a8 = 0, b8 = 0, r8;
  logic [2:0]  op8 = 0;
  logic        iv16 = 0, ir16, ov16, ordy16 = 1, z16, n16, c16, v16, busy16;
  logic [15:0] a16 = 0, b16 = 0, r16;
  logic [2:0]  op16 = 0;

  int nvec = 0, nerr = 0;

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .SrcA(a8), .SrcB(b8),
    .ALUControl(op8), .out_valid(ov8), .out_ready(ordy8), .ALUResult(r8),
    .Zero(z8), .Negative(n8), .Carry(c8), .Overflow(v8), .busy(busy8));

  alu_seq #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .SrcA(a16), .SrcB(b16),
    .ALUControl(op16), .out_valid(ov16), .out_ready(ordy16), .ALUResult(r16),
    .Zero(z16), .Negative(n16), .Carry(c16), .Overflow(v16), .busy(busy16));

  task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int g = 0;
    @(negedge clk);
    while (!ir8 && g < 100) begin @(negedge clk); g++; end
    if (!ir8) begin nvec++; nerr++; $display("FAIL send8_ready in_ready=%0b required 1", ir8); end
    iv8 = 1; op8 = op; a8 = a; b8 = b;
    @(posedge clk); #1;
    iv8 = 0; op8 = ~op; a8 = ~a; b8 = ~b;
  endtask

  task automatic do8(input vec_t t, output logic [7:0] r, output logic [3:0] f,
                     output int lat, output int nb);
    send8(t.op, t.a[7:0], t.b[7:0]);
    lat = 1; nb = 0;
    while (!ov8 && lat < 100) begin
      if (busy8) nb++;
      @(posedge clk); #1; lat++;
    end
    r = r8; f = {z8, n8, c8, v8};
  endtask

  task automatic send16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int g = 0;
    @(negedge clk);
    while (!ir16 && g < 100) begin @(negedge clk); g++; end
    if (!ir16) begin nvec++; nerr++; $display("FAIL send16_ready in_ready=%0b required 1", ir16); end
    iv16 = 1; op16 = op; a16 = a; b16 = b;
    @(posedge clk); #1;
    iv16 = 0; op16 = ~op; a16 = ~a; b16 = ~b;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if ({ov8, busy8, z8, n8, c8, v8} !== 6'b0 || r8 !== 8'h00) begin
      nerr++; $display("FAIL reset_outputs ov/busy/flags=%b result=%h required 000000/00", {ov8, busy8, z8, n8, c8, v8}, r8);
    end
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    nvec++; if (ir8 !== 1'b1 || ir16 !== 1'b1) begin
      nerr++; $display("FAIL reset_in_ready got %b%b required 11", ir8, ir16);
    end
  endtask

  task automatic test_ops8;
    vec_t tv[15];
    logic [7:0] r; logic [3:0] f; int lat, nb;
    tv = '{
      '{ADD,  16'hFF, 16'h01, 16'h00, 4'b1010, 8'd1},
      '{SUB,  16'h80, 16'h01, 16'h7F, 4'b0011, 8'd1},
      '{SUB,  16'h01, 16'h02, 16'hFF, 4'b0100, 8'd1},
      '{SLT,  16'hFE, 16'h01, 16'h01, 4'b0000, 8'd1},
      '{SLT,  16'h01, 16'hFE, 16'h00, 4'b1000, 8'd1},
      '{AND_, 16'hF0, 16'h3C, 16'h30, 4'b0000, 8'd1},
      '{OR_,  16'hA0, 16'h0A, 16'hAA, 4'b0100, 8'd1},
      '{XOR_, 16'hF0, 16'h3C, 16'hCC, 4'b0100, 8'd1},
      '{SLL,  16'h03, 16'hF9, 16'h06, 4'b0000, 8'd1},
      '{ADD,  16'h7F, 16'h01, 16'h80, 4'b0101, 8'd1},
      '{SUB,  16'h05, 16'h05, 16'h00, 4'b1010, 8'd1},
      '{MUL,  16'h0D, 16'h0B, 16'h8F, 4'b0100, 8'd9},
      '{MUL,  16'h10, 16'h10, 16'h00, 4'b1000, 8'd9},
      '{MUL,  16'hFF, 16'hFF, 16'h01, 4'b0000, 8'd9},
      '{MUL,  16'hFD, 16'h05, 16'hF1, 4'b0100, 8'd9}
    };
    ordy8 = 1;
    for (int i = 0; i < 15; i++) begin
      do8(tv[i], r, f, lat, nb);
      nvec++; if (r !== tv[i].r[7:0]) begin
        nerr++; $display("FAIL ops8[%0d] result=%h required %h", i, r, tv[i].r[7:0]);
      end
      nvec++; if (f !== tv[i].f) begin
        nerr++; $display("FAIL ops8[%0d] flags ZNCV=%b required %b", i, f, tv[i].f);
      end
      nvec++; if (lat !== int'(tv[i].lat) || nb !== int'(tv[i].lat) - 1) begin
        nerr++; $display("FAIL ops8[%0d] latency=%0d busy_cycles=%0d required %0d/%0d", i, lat, nb, tv[i].lat, tv[i].lat - 1);
      end
      nvec++; if (ir8 !== 1'b0) begin
        nerr++; $display("FAIL ops8[%0d] in_ready_in_done=%b required 0", i, ir8);
      end
      @(posedge clk); #1;
      nvec++; if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
        nerr++; $display("FAIL ops8[%0d] after_take out_valid/in_ready=%b%b required 01", i, ov8, ir8);
      end
    end
  endtask

  task automatic test_backpressure;
    ordy8 = 0;
    send8(ADD, 8'd3, 8'd4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); iv8 = 1; op8 = SUB; a8 = 8'h10; b8 = 8'h20;
      @(posedge clk); #1;
      nvec++; if (ov8 !== 1'b1 || ir8 !== 1'b0 || r8 !== 8'h07 || {z8, n8, c8, v8} !== 4'b0000) begin
        nerr++; $display("FAIL hold[%0d] ov/ir=%b%b result=%h flags=%b required 10/07/0000", k, ov8, ir8, r8, {z8, n8, c8, v8});
      end
    end
    @(negedge clk); iv8 = 0; ordy8 = 1;
    @(posedge clk); #1;
    nvec++; if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      nerr++; $display("FAIL hold_release ov/ir=%b%b required 01", ov8, ir8);
    end
    @(posedge clk); #1;
    nvec++; if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      nerr++; $display("FAIL hold_taken_once ov/ir=%b%b required 01", ov8, ir8);
    end
  endtask

  task automatic test_reset_mid_mul;
    vec_t t;
    logic [7:0] r; logic [3:0] f; int lat, nb;
    ordy8 = 1;
    send8(MUL, 8'd13, 8'd11);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    nvec++; if (ov8 !== 1'b0 || busy8 !== 1'b0 || ir8 !== 1'b1 || r8 !== 8'h00 || {z8, n8, c8, v8} !== 4'b0) begin
      nerr++; $display("FAIL mul_reset ov/busy/ir=%b%b%b result=%h flags=%b required 001/00/0000", ov8, busy8, ir8, r8, {z8, n8, c8, v8});
    end
    @(negedge clk); reset = 0;
    repeat (12) begin
      @(posedge clk); #1;
      nvec++; if (ov8 !== 1'b0) begin
        nerr++; $display("FAIL mul_reset_no_result out_valid=%b required 0", ov8);
      end
    end
    t = '{OR_, 16'hA0, 16'h0A, 16'hAA, 4'b0100, 8'd1};
    do8(t, r, f, lat, nb);
    nvec++; if (r !== 8'hAA || f !== 4'b0100 || lat !== 1) begin
      nerr++; $display("FAIL post_reset_or result=%h flags=%b lat=%0d required aa/0100/1", r, f, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_width16;
    vec_t tv[6];
    int lat, nb;
    tv = '{
      '{SLL,  16'h0001, 16'h001F, 16'h8000, 4'b0100, 8'd1},
      '{MUL,  16'h0100, 16'h0100, 16'h0000, 4'b1000, 8'd17},
      '{XOR_, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000, 8'd1},
      '{ADD,  16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 8'd1},
      '{SUB,  16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 8'd1},
      '{MUL,  16'h1234, 16'h0003, 16'h369C, 4'b0000, 8'd17}
    };
    ordy16 = 1;
    for (int i = 0; i < 6; i++) begin
      send16(tv[i].op, tv[i].a, tv[i].b);
      lat = 1; nb = 0;
      while (!ov16 && lat < 100) begin
        if (busy16) nb++;
        @(posedge clk); #1; lat++;
      end
      nvec++; if (r16 !== tv[i].r || {z16, n16, c16, v16} !== tv[i].f) begin
        nerr++; $display("FAIL w16[%0d] result=%h flags=%b required %h/%b", i, r16, {z16, n16, c16, v16}, tv[i].r, tv[i].f);
      end
      nvec++; if (lat !== int'(tv[i].lat) || nb !== int'(tv[i].lat) - 1) begin
        nerr++; $display("FAIL w16[%0d] latency=%0d busy_cycles=%0d required %0d/%0d", i, lat, nb, tv[i].lat, tv[i].lat - 1);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset;
    test_ops8;
    test_backpressure;
    test_reset_mid_mul;
    test_width16;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
